// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - four-function calculator key-entry FSM with optional sequential divider
//
// Optional feature macro: CALC_DIV_EN
//   defined   : key 10 is the divide operator, served by a 27-step restoring divider
//   undefined : divider omitted, key 10 ignored everywhere, CALC always lasts one cycle
//
// Ports:
//   clk         in   1  key clock, all state changes on the rising edge
//   rst_n       in   1  asynchronous active-low reset
//   key_val     in   4  key code: 0-9 digit, 10 div, 11 clear, 12 add, 13 sub, 14 mul, 15 equals
//   key_pressed in   1  single-cycle strobe qualifying key_val
//   disp_mag    out 27  magnitude of the displayed value
//   disp_neg    out  1  displayed value is negative
//   err         out  1  in ERR state
//   busy        out  1  in CALC state
module calc_entry_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_val,
    input  logic        key_pressed,
    output logic [26:0] disp_mag,
    output logic        disp_neg,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {ENTER_A, ENTER_B, CALC, SHOW, ERR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    localparam logic signed [41:0] MAX_MAG = 42'sd99_999_999;

    state_t             state, state_nx;
    logic signed [27:0] a_reg, a_nx;
    logic [13:0]        b_reg, b_nx;
    logic [2:0]         cnt_a, cnt_a_nx;
    logic [2:0]         cnt_b, cnt_b_nx;
    // A zero typed into B does not advance cnt_b, yet it still counts as an
    // entered operand (so "7 / 0 =" reaches the divide-by-zero error).
    logic               b_seen, b_seen_nx;
    op_t                op_reg, op_nx;
    op_t                chain_op, chain_op_nx;
    logic               chain, chain_nx;
    logic signed [27:0] res_reg, res_nx;

    // key decode
    logic is_digit, is_op, is_eq, is_clr;
    op_t  key_op;

    always_comb begin
        is_digit = key_pressed && (key_val <= 4'd9);
        is_clr   = key_pressed && (key_val == 4'd11);
        is_eq    = key_pressed && (key_val == 4'd15);
        is_op    = 1'b0;
        key_op   = OP_ADD;
        if (key_pressed) begin
            case (key_val)
                4'd12: begin is_op = 1'b1; key_op = OP_ADD; end
                4'd13: begin is_op = 1'b1; key_op = OP_SUB; end
                4'd14: begin is_op = 1'b1; key_op = OP_MUL; end
`ifdef CALC_DIV_EN
                4'd10: begin is_op = 1'b1; key_op = OP_DIV; end
`endif
                default: ;
            endcase
        end
    end

    // digit accumulation: 4 digits max, leading zeros do not use up a slot
    logic [27:0]        a_u;
    logic signed [27:0] a_dig;
    logic [2:0]         cnt_a_dig;
    logic [13:0]        b_dig;
    logic [2:0]         cnt_b_dig;

    always_comb begin
        a_u       = a_reg;
        a_dig     = a_reg;
        cnt_a_dig = cnt_a;
        if (cnt_a != 3'd4 && !(a_reg == 28'sd0 && key_val == 4'd0)) begin
            a_dig     = a_u * 28'd10 + {24'd0, key_val};
            cnt_a_dig = cnt_a + 3'd1;
        end
        b_dig     = b_reg;
        cnt_b_dig = cnt_b;
        if (cnt_b != 3'd4 && !(b_reg == 14'd0 && key_val == 4'd0)) begin
            b_dig     = b_reg * 14'd10 + {10'd0, key_val};
            cnt_b_dig = cnt_b + 3'd1;
        end
    end

    // single-cycle arithmetic, wide enough that the overflow test is exact
    logic signed [41:0] a_w, b_w, ar_w;

    always_comb begin
        a_w = 42'(a_reg);
        b_w = $signed({28'd0, b_reg});
        case (op_reg)
            OP_ADD:  ar_w = a_w + b_w;
            OP_SUB:  ar_w = a_w - b_w;
            OP_MUL:  ar_w = a_w * b_w;
            default: ar_w = 42'sd0;
        endcase
    end

`ifdef CALC_DIV_EN
    // restoring divider on |A| / B, one quotient bit per cycle, MSB first
    logic [26:0]        dq_reg, dq_nx;
    logic [13:0]        dr_reg, dr_nx;
    logic [4:0]         dcnt_reg, dcnt_nx;
    logic               dneg_reg, dneg_nx;
    logic [26:0]        a_mag;
    logic [14:0]        d_sh;
    logic [13:0]        d_rstep;
    logic [26:0]        d_qstep;
    logic signed [41:0] div_w;

    always_comb begin
        a_mag = a_reg[27] ? 27'(-a_reg) : a_reg[26:0];
        d_sh  = {dr_reg, dq_reg[26]};
        if (d_sh >= {1'b0, b_reg}) begin
            d_rstep = 14'(d_sh - {1'b0, b_reg});
            d_qstep = {dq_reg[25:0], 1'b1};
        end else begin
            d_rstep = d_sh[13:0];
            d_qstep = {dq_reg[25:0], 1'b0};
        end
        // negating a zero quotient stays zero, so no negative zero appears
        div_w = dneg_reg ? -$signed({15'd0, d_qstep}) : $signed({15'd0, d_qstep});
    end
`endif

    logic               fin;
    logic signed [41:0] fin_val;

    always_comb begin
        state_nx    = state;
        a_nx        = a_reg;
        b_nx        = b_reg;
        cnt_a_nx    = cnt_a;
        cnt_b_nx    = cnt_b;
        b_seen_nx   = b_seen;
        op_nx       = op_reg;
        chain_op_nx = chain_op;
        chain_nx    = chain;
        res_nx      = res_reg;
        fin         = 1'b0;
        fin_val     = 42'sd0;
`ifdef CALC_DIV_EN
        dq_nx       = dq_reg;
        dr_nx       = dr_reg;
        dcnt_nx     = dcnt_reg;
        dneg_nx     = dneg_reg;
`endif
        if (is_clr) begin
            state_nx  = ENTER_A;
            a_nx      = '0;
            b_nx      = '0;
            cnt_a_nx  = '0;
            cnt_b_nx  = '0;
            b_seen_nx = 1'b0;
            op_nx     = OP_ADD;
            chain_nx  = 1'b0;
            res_nx    = '0;
`ifdef CALC_DIV_EN
            dq_nx     = '0;
            dr_nx     = '0;
            dcnt_nx   = '0;
            dneg_nx   = 1'b0;
`endif
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_digit) begin
                        a_nx     = a_dig;
                        cnt_a_nx = cnt_a_dig;
                    end else if (is_op) begin
                        op_nx     = key_op;
                        b_nx      = '0;
                        cnt_b_nx  = '0;
                        b_seen_nx = 1'b0;
                        state_nx  = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        b_nx      = b_dig;
                        cnt_b_nx  = cnt_b_dig;
                        b_seen_nx = 1'b1;
                    end else if ((is_op || is_eq) && (cnt_b != 3'd0 || b_seen)) begin
                        state_nx    = CALC;
                        chain_nx    = is_op;
                        chain_op_nx = key_op;
`ifdef CALC_DIV_EN
                        dq_nx       = a_mag;
                        dr_nx       = '0;
                        dcnt_nx     = '0;
                        dneg_nx     = a_reg[27];
`endif
                    end else if (is_op) begin
                        op_nx = key_op;
                    end
                end
                CALC: begin
                    fin     = 1'b1;
                    fin_val = ar_w;
`ifdef CALC_DIV_EN
                    if (op_reg == OP_DIV) begin
                        fin = 1'b0;
                        if (b_reg == 14'd0) begin
                            state_nx = ERR;
                        end else begin
                            dq_nx   = d_qstep;
                            dr_nx   = d_rstep;
                            dcnt_nx = dcnt_reg + 5'd1;
                            if (dcnt_reg == 5'd26) begin
                                fin     = 1'b1;
                                fin_val = div_w;
                            end
                        end
                    end
`endif
                    if (fin) begin
                        if (fin_val > MAX_MAG || fin_val < -MAX_MAG) begin
                            state_nx = ERR;
                        end else if (chain) begin
                            res_nx    = 28'(fin_val);
                            a_nx      = 28'(fin_val);
                            b_nx      = '0;
                            cnt_b_nx  = '0;
                            b_seen_nx = 1'b0;
                            op_nx     = chain_op;
                            chain_nx  = 1'b0;
                            state_nx  = ENTER_B;
                        end else begin
                            res_nx   = 28'(fin_val);
                            state_nx = SHOW;
                        end
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        a_nx      = {24'd0, key_val};
                        cnt_a_nx  = (key_val != 4'd0) ? 3'd1 : 3'd0;
                        b_nx      = '0;
                        cnt_b_nx  = '0;
                        b_seen_nx = 1'b0;
                        state_nx  = ENTER_A;
                    end else if (is_op) begin
                        a_nx      = res_reg;
                        b_nx      = '0;
                        cnt_b_nx  = '0;
                        b_seen_nx = 1'b0;
                        op_nx     = key_op;
                        state_nx  = ENTER_B;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENTER_A;
            a_reg    <= '0;
            b_reg    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            b_seen   <= 1'b0;
            op_reg   <= OP_ADD;
            chain_op <= OP_ADD;
            chain    <= 1'b0;
            res_reg  <= '0;
        end else begin
            state    <= state_nx;
            a_reg    <= a_nx;
            b_reg    <= b_nx;
            cnt_a    <= cnt_a_nx;
            cnt_b    <= cnt_b_nx;
            b_seen   <= b_seen_nx;
            op_reg   <= op_nx;
            chain_op <= chain_op_nx;
            chain    <= chain_nx;
            res_reg  <= res_nx;
        end
    end

`ifdef CALC_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_reg   <= '0;
            dr_reg   <= '0;
            dcnt_reg <= '0;
            dneg_reg <= 1'b0;
        end else begin
            dq_reg   <= dq_nx;
            dr_reg   <= dr_nx;
            dcnt_reg <= dcnt_nx;
            dneg_reg <= dneg_nx;
        end
    end
`endif

    // display selection
    logic signed [27:0] disp_val;

    always_comb begin
        case (state)
            ENTER_A:    disp_val = a_reg;
            ENTER_B:    disp_val = (cnt_b != 3'd0) ? $signed({14'd0, b_reg}) : a_reg;
            CALC, SHOW: disp_val = res_reg;
            default:    disp_val = '0;
        endcase
        disp_neg = disp_val[27];
        disp_mag = disp_val[27] ? 27'(-disp_val) : disp_val[26:0];
        err      = (state == ERR);
        busy     = (state == CALC);
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - self-checking bench for calc_entry_fsm
module tb_calc_entry_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_val = 4'd0;
    logic        key_pressed = 1'b0;
    logic [26:0] disp_mag;
    logic        disp_neg, err, busy;

    calc_entry_fsm dut (
        .clk(clk), .rst_n(rst_n), .key_val(key_val), .key_pressed(key_pressed),
        .disp_mag(disp_mag), .disp_neg(disp_neg), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        kp;
        logic [3:0]  kv;
        logic [26:0] mag;
        logic        neg;
        logic        er;
        logic        bz;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic kp, input logic [3:0] kv, input logic [26:0] mag,
                       input logic neg, input logic er, input logic bz);
        vec_t v;
        v.kp = kp; v.kv = kv; v.mag = mag; v.neg = neg; v.er = er; v.bz = bz;
        tbl.push_back(v);
    endtask

    task automatic tick(input logic kp, input logic [3:0] kv);
        key_pressed = kp;
        key_val     = kv;
        @(posedge clk);
        #1;
        key_pressed = 1'b0;
    endtask

    task automatic check(input string name, input logic [26:0] em, input logic en,
                         input logic ee, input logic eb);
        n_vec++;
        if (disp_mag !== em || disp_neg !== en || err !== ee || busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got mag=%0d neg=%0b err=%0b busy=%0b, want mag=%0d neg=%0b err=%0b busy=%0b",
                     name, disp_mag, disp_neg, err, busy, em, en, ee, eb);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // behavioural reference: whole results computed at once, CALC is a countdown
    localparam int M_A = 0, M_B = 1, M_CALC = 2, M_SHOW = 3, M_ERR = 4;
    int     m_mode, m_ca, m_cb, m_op, m_chain_op, m_left;
    longint m_a, m_b, m_res, m_val;
    bit     m_chain, m_perr, m_bseen;

    task automatic model_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_res = 0;
        m_op = 12; m_chain = 0; m_chain_op = 12; m_left = 0; m_perr = 0; m_bseen = 0;
    endtask

    task automatic model_step(input bit kp, input int kv);
        bit dig, clr, eq, opk;
        dig = kp && kv <= 9;
        clr = kp && kv == 11;
        eq  = kp && kv == 15;
        opk = kp && (kv == 12 || kv == 13 || kv == 14 || (DIV_EN && kv == 10));
        if (clr) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_A: begin
                if (dig) begin
                    if (m_ca < 4 && !(m_a == 0 && kv == 0)) begin m_a = m_a * 10 + kv; m_ca++; end
                end else if (opk) begin
                    m_op = kv; m_b = 0; m_cb = 0; m_bseen = 0; m_mode = M_B;
                end
            end
            M_B: begin
                if (dig) begin
                    m_bseen = 1;
                    if (m_cb < 4 && !(m_b == 0 && kv == 0)) begin m_b = m_b * 10 + kv; m_cb++; end
                end else if ((opk || eq) && (m_cb > 0 || m_bseen)) begin
                    m_chain = opk; m_chain_op = kv; m_perr = 0; m_left = 1; m_val = 0;
                    case (m_op)
                        12: m_val = m_a + m_b;
                        13: m_val = m_a - m_b;
                        14: m_val = m_a * m_b;
                        default: begin
                            if (m_b == 0) m_perr = 1;
                            else begin m_val = m_a / m_b; m_left = 27; end
                        end
                    endcase
                    if (m_val > 99999999 || m_val < -99999999) m_perr = 1;
                    m_mode = M_CALC;
                end else if (opk) begin
                    m_op = kv;
                end
            end
            M_CALC: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_perr) m_mode = M_ERR;
                    else if (m_chain) begin
                        m_res = m_val; m_a = m_val; m_b = 0; m_cb = 0; m_bseen = 0;
                        m_op = m_chain_op; m_chain = 0; m_mode = M_B;
                    end else begin
                        m_res = m_val; m_mode = M_SHOW;
                    end
                end
            end
            M_SHOW: begin
                if (dig) begin
                    m_a = kv; m_ca = (kv != 0) ? 1 : 0; m_b = 0; m_cb = 0; m_bseen = 0; m_mode = M_A;
                end else if (opk) begin
                    m_a = m_res; m_b = 0; m_cb = 0; m_bseen = 0; m_op = kv; m_mode = M_B;
                end
            end
            default: ;
        endcase
    endtask

    function automatic longint model_disp();
        case (m_mode)
            M_A:            return m_a;
            M_B:            return (m_cb > 0) ? m_b : m_a;
            M_CALC, M_SHOW: return m_res;
            default:        return 0;
        endcase
    endfunction

    task automatic check_model(input string name);
        longint v, mg;
        v  = model_disp();
        mg = (v < 0) ? -v : v;
        check(name, 27'(mg), v < 0, m_mode == M_ERR, m_mode == M_CALC);
    endtask

    initial begin
        int nb;
        // 1,2,+,3,4,= -> 46
        add(1, 1, 1, 0, 0, 0);  add(1, 2, 12, 0, 0, 0); add(1, 12, 12, 0, 0, 0);
        add(1, 3, 3, 0, 0, 0);  add(1, 4, 34, 0, 0, 0); add(1, 15, 0, 0, 0, 1);
        add(0, 0, 46, 0, 0, 0); add(0, 0, 46, 0, 0, 0); add(1, 11, 0, 0, 0, 0);
        // 5,-,9,= -> -4 ; *,3,= -> -12
        add(1, 5, 5, 0, 0, 0);  add(1, 13, 5, 0, 0, 0); add(1, 9, 9, 0, 0, 0);
        add(1, 15, 0, 0, 0, 1); add(0, 0, 4, 1, 0, 0);  add(1, 14, 4, 1, 0, 0);
        add(1, 3, 3, 0, 0, 0);  add(1, 15, 4, 1, 0, 1); add(0, 0, 12, 1, 0, 0);
        add(1, 11, 0, 0, 0, 0);
        // 9,9,9,9,9,*,9,9,9,9,= -> 99980001 ; *,2,= -> ERR
        add(1, 9, 9, 0, 0, 0);    add(1, 9, 99, 0, 0, 0);  add(1, 9, 999, 0, 0, 0);
        add(1, 9, 9999, 0, 0, 0); add(1, 9, 9999, 0, 0, 0); add(1, 14, 9999, 0, 0, 0);
        add(1, 9, 9, 0, 0, 0);    add(1, 9, 99, 0, 0, 0);  add(1, 9, 999, 0, 0, 0);
        add(1, 9, 9999, 0, 0, 0); add(1, 15, 0, 0, 0, 1);
        add(0, 0, 99980001, 0, 0, 0); add(1, 14, 99980001, 0, 0, 0); add(1, 2, 2, 0, 0, 0);
        add(1, 15, 99980001, 0, 0, 1); add(0, 0, 0, 0, 1, 0);
        add(1, 5, 0, 0, 1, 0);  add(1, 15, 0, 0, 1, 0); add(1, 11, 0, 0, 0, 0);
        // 8,+,2,*,3,= -> chained 30
        add(1, 8, 8, 0, 0, 0);  add(1, 12, 8, 0, 0, 0); add(1, 2, 2, 0, 0, 0);
        add(1, 14, 0, 0, 0, 1); add(0, 0, 10, 0, 0, 0); add(1, 3, 3, 0, 0, 0);
        add(1, 15, 10, 0, 0, 1); add(0, 0, 30, 0, 0, 0);
        // SHOW digit restarts A, leading zeros, '=' no-op in ENTER_A, op replacement
        add(1, 0, 0, 0, 0, 0);  add(1, 0, 0, 0, 0, 0);  add(1, 7, 7, 0, 0, 0);
        add(1, 15, 7, 0, 0, 0); add(1, 12, 7, 0, 0, 0); add(1, 13, 7, 0, 0, 0);
        add(1, 2, 2, 0, 0, 0);  add(1, 15, 30, 0, 0, 1); add(0, 0, 5, 0, 0, 0);
        // SHOW operator reuses the result; zero into empty B keeps showing A
        add(1, 12, 5, 0, 0, 0); add(1, 0, 5, 0, 0, 0);  add(1, 6, 6, 0, 0, 0);
        add(1, 15, 5, 0, 0, 1); add(0, 0, 11, 0, 0, 0); add(1, 15, 11, 0, 0, 0);
        // -4 + 4 = 0 must not be negative
        add(1, 11, 0, 0, 0, 0); add(1, 5, 5, 0, 0, 0);  add(1, 13, 5, 0, 0, 0);
        add(1, 9, 9, 0, 0, 0);  add(1, 15, 0, 0, 0, 1); add(0, 0, 4, 1, 0, 0);
        add(1, 12, 4, 1, 0, 0); add(1, 4, 4, 0, 0, 0);  add(1, 15, 4, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0);

        #12;
        check("reset", 27'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].kp, tbl[i].kv);
            check($sformatf("tbl[%0d]", i), tbl[i].mag, tbl[i].neg, tbl[i].er, tbl[i].bz);
        end

        // keys other than clear are dropped while busy
        tick(1, 11); tick(1, 1); tick(1, 12); tick(1, 1); tick(1, 15);
        check("busy_calc", 27'd0, 1'b0, 1'b0, 1'b1);
        tick(1, 5);
        check("busy_drop", 27'd2, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        check("busy_drop_after", 27'd2, 1'b0, 1'b0, 1'b0);

        // clear during a one-cycle CALC aborts it
        tick(1, 11); tick(1, 3); tick(1, 12); tick(1, 3); tick(1, 15);
        tick(1, 11);
        check("clr_mid_calc", 27'd0, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        check("clr_mid_calc_hold", 27'd0, 1'b0, 1'b0, 1'b0);

`ifdef CALC_DIV_EN
        // 100 / 7 = 14 with 27 busy cycles
        tick(1, 1); tick(1, 0); tick(1, 0); tick(1, 10); tick(1, 7); tick(1, 15);
        nb = 0;
        for (int i = 0; i < 60 && busy === 1'b1; i++) begin
            nb++;
            tick(0, 0);
        end
        check_int("div_busy_cycles", nb, 27);
        check("div_result", 27'd14, 1'b0, 1'b0, 1'b0);
        // 7 / 0 -> ERR after one CALC cycle
        tick(1, 11); tick(1, 7); tick(1, 10); tick(1, 0); tick(1, 15);
        check("div0_calc", 27'd0, 1'b0, 1'b0, 1'b1);
        tick(0, 0);
        check("div0_err", 27'd0, 1'b0, 1'b1, 1'b0);
        // clear mid-divide
        tick(1, 11); tick(1, 9); tick(1, 10); tick(1, 2); tick(1, 15);
        for (int i = 0; i < 5; i++) tick(0, 0);
        check("div_mid_busy", 27'd0, 1'b0, 1'b0, 1'b1);
        tick(1, 11);
        check("div_mid_clear", 27'd0, 1'b0, 1'b0, 1'b0);
        tick(1, 7);
        check("div_after_clear", 27'd7, 1'b0, 1'b0, 1'b0);
`else
        // key 10 is ignored without the divider
        tick(1, 11); tick(1, 5); tick(1, 10);
        check("nodiv_key10", 27'd5, 1'b0, 1'b0, 1'b0);
        tick(1, 3);
        check("nodiv_digits", 27'd53, 1'b0, 1'b0, 1'b0);
`endif

        // asynchronous reset in ENTER_B
        tick(1, 11); tick(1, 3); tick(1, 12); tick(1, 4);
        check("pre_rst", 27'd4, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst", 27'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_hold", 27'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1, 7);
        check("post_rst_key", 27'd7, 1'b0, 1'b0, 1'b0);

        // randomized run against the reference model
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bit kp;
            int kv, r;
            kp = ($urandom_range(0, 99) >= 45);
            r  = $urandom_range(0, 99);
            if (!kp)         kv = $urandom_range(0, 15);
            else if (r < 55) kv = $urandom_range(0, 9);
            else if (r < 80) begin
                case ($urandom_range(0, 3))
                    0:       kv = 10;
                    1:       kv = 12;
                    2:       kv = 13;
                    default: kv = 14;
                endcase
            end
            else if (r < 95) kv = 15;
            else             kv = 11;
            tick(kp, 4'(kv));
            model_step(kp, kv);
            check_model($sformatf("rand[%0d] kp=%0b key=%0d", i, kp, kv));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
